// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: computes a - b - bin one bit per cycle, LSB first,
// with a start/busy/done handshake and registered result outputs.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, d_q, d_d;
  logic             brw_q, brw_d, bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             diff, nb, last;

  always_comb begin
    diff = a_q[0] ^ b_q[0] ^ brw_q;
    nb   = (~a_q[0] & b_q[0]) | (b_q[0] & brw_q) | (brw_q & ~a_q[0]);
    last = (cnt_q == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last)  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: capture on accept, one bit per RUN cycle, publish on the last bit
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    brw_d  = brw_q;
    cnt_d  = cnt_q;
    d_d    = d_q;
    bout_d = bout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d   = a;
          b_d   = b;
          brw_d = bin;
          cnt_d = '0;
          res_d = '0;
        end
      end
      S_RUN: begin
        a_d               = a_q >> 1;
        b_d               = b_q >> 1;
        res_d             = res_q >> 1;
        res_d[WIDTH-1]    = diff;
        brw_d             = nb;
        cnt_d             = cnt_q + CW'(1);
        if (last) begin
          d_d    = res_d;
          bout_d = nb;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      brw_q  <= 1'b0;
      cnt_q  <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      brw_q  <= brw_d;
      cnt_q  <= cnt_d;
      d_q    <= d_d;
      bout_q <= bout_d;
    end
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
    d    = d_q;
    bout = bout_q;
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8): directed cases, continuous
// start, mid-run reset, and a randomized sweep against an arithmetic model.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk, rst, start, bin;
  logic [W-1:0] a, b;
  logic         busy, done, bout;
  logic [W-1:0] d;

  int n_tests = 0;
  int n_fail  = 0;
  int last_d  = 0;
  int last_bo = 0;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .d(d), .bout(bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic binv, input bit chg, input bit noise);
    int r;
    r = int'(av) - int'(bv) - int'(binv);
    a = av; b = bv; bin = binv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (chg) begin a = '0; b = '0; bin = 1'b0; end
    for (int i = 0; i < W; i++) begin
      check("busy_run", busy, 1);
      check("done_run", done, 0);
      check("d_hold", d, last_d);
      check("bout_hold", bout, last_bo);
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_pulse", done, 1);
    check("busy_done", busy, 0);
    check("d", d, r & 255);
    check("bout", bout, (r < 0) ? 1 : 0);
    last_d  = r & 255;
    last_bo = (r < 0) ? 1 : 0;
    @(negedge clk);
    check("done_off", done, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    int  r;
    bit  prev_done;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_d", d, 0);
    check("rst_bout", bout, 0);
    rst = 1'b0;
    @(negedge clk);

    do_op(8'h05, 8'h03, 1'b0, 1'b0, 1'b0);
    do_op(8'h03, 8'h05, 1'b0, 1'b0, 1'b0);
    do_op(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
    do_op(8'h80, 8'h7F, 1'b1, 1'b0, 1'b1);

    // start held high: one operation every W+2 cycles
    a = 8'hA5; b = 8'h3C; bin = 1'b1; start = 1'b1;
    r = int'(8'hA5) - int'(8'h3C) - 1;
    prev_done = 1'b0;
    for (int i = 0; i < 3 * (W + 2); i++) begin
      @(negedge clk);
      check("cont_busy", busy, ((i % (W + 2)) < W) ? 1 : 0);
      check("cont_done", done, ((i % (W + 2)) == W) ? 1 : 0);
      check("cont_dbl", prev_done & done, 0);
      if ((i % (W + 2)) == W) begin
        check("cont_d", d, r & 255);
        check("cont_bout", bout, (r < 0) ? 1 : 0);
      end
      prev_done = done;
    end
    start = 1'b0;
    last_d = r & 255;
    last_bo = (r < 0) ? 1 : 0;

    // reset applied at the 4th RUN cycle
    a = 8'h12; b = 8'h34; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_d", d, 0);
    check("abort_bout", bout, 0);
    last_d = 0;
    last_bo = 0;
    do_op(8'h40, 8'h41, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 1000; n++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1, 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
